// File: rtl/md_pkg.sv
// md_pkg: opcodes, default latencies, FSM states and opcode predicates for the md issue controller
package md_pkg;
  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;
  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;
  localparam int CNT_W_DEF   = 4;
  typedef enum logic {IDLE, RUN} md_state_e;
  function automatic logic is_long_op(input logic [3:0] op);
    return op >= MD_MULT && op <= MD_DIVU;
  endfunction
  function automatic logic is_md_op(input logic [3:0] op);
    return op >= MD_MULT && op <= MD_MTLO;
  endfunction
  function automatic logic is_mt_op(input logic [3:0] op);
    return op == MD_MTHI || op == MD_MTLO;
  endfunction
  function automatic logic is_mul_op(input logic [3:0] op);
    return op == MD_MULT || op == MD_MULTU;
  endfunction
endpackage

// File: rtl/md_issue_ctrl_if.sv
// md_issue_ctrl_if: EX-stage request side and datapath/pipeline control side of the md issue controller
interface md_issue_ctrl_if;
  logic       e_valid;
  logic [3:0] e_md_op;
  logic       d_md_use;
  logic       flush;
  logic       md_start;
  logic [3:0] md_sel;
  logic       busy;
  logic       stall;
  logic       commit;
  logic       issue_err;
  modport master (output e_valid, e_md_op, d_md_use, flush,
                  input  md_start, md_sel, busy, stall, commit, issue_err);
  modport slave  (input  e_valid, e_md_op, d_md_use, flush,
                  output md_start, md_sel, busy, stall, commit, issue_err);
endinterface

// File: rtl/md_lat_counter.sv
// md_lat_counter: loadable down-counter that parks at zero and flags the last busy cycle
module md_lat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             term_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // load wins; otherwise count down and hold at zero
  always_comb cnt_d = load_i ? load_val_i : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
  // counter register
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
  assign term_o = cnt_q == CNT_W'(1);
endmodule

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: launches md ops, times their latency, stalls dependents and flags issue-while-busy
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  md_issue_ctrl_if.slave  bus
);
  md_state_e  state_q, state_d;
  logic       err_q, err_d;
  logic       run, long_op, launch, load, term;
  logic [3:0] op;
  assign op      = bus.e_md_op;
  assign run     = state_q == RUN;
  assign long_op = is_long_op(op);
  assign launch  = bus.e_valid & ~bus.flush & ~run & (long_op | is_mt_op(op));
  assign load    = launch & long_op;
  md_lat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .load_val_i (CNT_W'(is_mul_op(op) ? MUL_LAT : DIV_LAT)),
    .term_o     (term)
  );
  // next state, sticky error and pipeline/datapath outputs
  always_comb begin
    state_d       = run ? (term ? IDLE : RUN) : (load ? RUN : IDLE);
    err_d         = err_q | (bus.e_valid & is_md_op(op) & run);
    bus.md_start  = launch;
    bus.md_sel    = bus.e_valid ? op : MD_NONE;
    bus.busy      = run | load;
    bus.stall     = bus.d_md_use & (run | load);
    bus.commit    = run & term;
    bus.issue_err = err_q;
  end
  // state and error registers
  always_ff @(posedge clk) begin
    state_q <= reset ? IDLE : state_d;
    err_q   <= reset ? 1'b0 : err_d;
  end
endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: vector table, corner sequences and randomized run against a cycle-count reference model
module tb_md_issue_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  md_issue_ctrl_if bus();
  md_issue_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  int tests = 0, failed = 0, cyc = 0;
  bit m_run = 0, m_err = 0;
  int m_end = 0;
  bit e_start, e_busy, e_stall, e_commit, e_err, m_load;
  logic [3:0] e_sel, cur_op;
  bit s_start, s_busy, s_commit, s_err;

  typedef struct packed {
    bit r, v; logic [3:0] op; bit du, fl;
    bit st; logic [3:0] sel; bit bz, sl, cm, er;
  } vec_t;
  vec_t tab[15];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s cyc=%0d got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic drive(input bit r, v, input logic [3:0] op, input bit du, fl);
    bit lng, launch;
    reset = r; bus.e_valid = v; bus.e_md_op = op; bus.d_md_use = du; bus.flush = fl;
    cur_op = op;
    lng = op >= 1 && op <= 4;
    launch = v && !fl && !m_run && (lng || op == 7 || op == 8);
    m_load = launch && lng;
    e_start = launch;
    e_sel = v ? op : 4'd0;
    e_busy = m_run || m_load;
    e_stall = du && e_busy;
    e_commit = m_run && cyc == m_end;
    e_err = m_err;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_run = 0; m_err = 0;
    end else begin
      if (bus.e_valid && cur_op >= 1 && cur_op <= 8 && m_run) m_err = 1;
      if (e_commit) m_run = 0;
      else if (m_load) begin
        m_run = 1;
        m_end = cyc + ((cur_op <= 2) ? 5 : 10);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic chk_model();
    chk("md_start", bus.md_start, e_start);
    if (cur_op <= 8) chk("md_sel", bus.md_sel, e_sel);
    chk("busy", bus.busy, e_busy);
    chk("stall", bus.stall, e_stall);
    chk("commit", bus.commit, e_commit);
    chk("issue_err", bus.issue_err, e_err);
  endtask

  task automatic run_cyc(input bit r, v, input logic [3:0] op, input bit du, fl);
    drive(r, v, op, du, fl);
    @(negedge clk);
    chk_model();
    s_start = bus.md_start; s_busy = bus.busy; s_commit = bus.commit; s_err = bus.issue_err;
    tick();
  endtask

  initial begin
    int nb, nc, cpos;
    tab[0]  = '{1,0,4'd0,0,0, 0,4'd0,0,0,0,0};
    tab[1]  = '{0,1,4'd1,1,0, 1,4'd1,1,1,0,0};
    tab[2]  = '{0,0,4'd0,1,0, 0,4'd0,1,1,0,0};
    tab[3]  = '{0,0,4'd0,1,0, 0,4'd0,1,1,0,0};
    tab[4]  = '{0,0,4'd0,1,0, 0,4'd0,1,1,0,0};
    tab[5]  = '{0,0,4'd0,1,0, 0,4'd0,1,1,0,0};
    tab[6]  = '{0,0,4'd0,1,0, 0,4'd0,1,1,1,0};
    tab[7]  = '{0,1,4'd5,0,0, 0,4'd5,0,0,0,0};
    tab[8]  = '{0,1,4'd7,0,0, 1,4'd7,0,0,0,0};
    tab[9]  = '{0,1,4'd6,1,0, 0,4'd6,0,0,0,0};
    tab[10] = '{0,1,4'd1,1,1, 0,4'd1,0,0,0,0};
    tab[11] = '{0,1,4'd8,1,0, 1,4'd8,0,0,0,0};
    tab[12] = '{0,1,4'd3,0,0, 1,4'd3,1,0,0,0};
    tab[13] = '{0,1,4'd2,1,0, 0,4'd2,1,1,0,0};
    tab[14] = '{0,0,4'd0,0,0, 0,4'd0,1,0,0,1};
    drive(1, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 15; i++) begin
      drive(tab[i].r, tab[i].v, tab[i].op, tab[i].du, tab[i].fl);
      @(negedge clk);
      chk($sformatf("tab%0d.md_start", i), bus.md_start, tab[i].st);
      chk($sformatf("tab%0d.md_sel", i), bus.md_sel, tab[i].sel);
      chk($sformatf("tab%0d.busy", i), bus.busy, tab[i].bz);
      chk($sformatf("tab%0d.stall", i), bus.stall, tab[i].sl);
      chk($sformatf("tab%0d.commit", i), bus.commit, tab[i].cm);
      chk($sformatf("tab%0d.issue_err", i), bus.issue_err, tab[i].er);
      tick();
    end
    // divu with independent followers: busy 11 cycles, no stall, commit at +10
    run_cyc(1, 0, 0, 0, 0);
    nb = 0; nc = 0; cpos = -1;
    for (int k = 0; k <= 12; k++) begin
      run_cyc(0, k == 0, k == 0 ? 4'd4 : 4'd0, 0, 0);
      nb += s_busy; nc += s_commit;
      if (s_commit) cpos = k;
    end
    chk("divu_busy_cycles", nb, 11);
    chk("divu_commit_count", nc, 1);
    chk("divu_commit_pos", cpos, 10);
    // mult killed by flush: no launch, no commit
    run_cyc(0, 1, 1, 1, 1);
    chk("flush_start", s_start, 0);
    nb = 0; nc = 0;
    for (int k = 0; k < 12; k++) begin
      run_cyc(0, 0, 0, 1, 0);
      nb += s_busy; nc += s_commit;
    end
    chk("flush_busy", nb, 0);
    chk("flush_commit", nc, 0);
    // reset in the middle of a div run
    run_cyc(0, 1, 3, 0, 0);
    run_cyc(0, 0, 0, 0, 0);
    run_cyc(0, 0, 0, 0, 0);
    run_cyc(1, 0, 0, 0, 0);
    nb = 0; nc = 0;
    for (int k = 0; k < 12; k++) begin
      run_cyc(0, 0, 0, 1, 0);
      nb += s_busy; nc += s_commit;
    end
    chk("abort_busy", nb, 0);
    chk("abort_commit", nc, 0);
    nb = 0; cpos = -1;
    for (int k = 0; k <= 12; k++) begin
      run_cyc(0, k == 0, k == 0 ? 4'd3 : 4'd0, 0, 0);
      nb += s_busy;
      if (s_commit) cpos = k;
    end
    chk("div_after_abort_busy", nb, 11);
    chk("div_after_abort_commit", cpos, 10);
    // issue while running: no launch, sticky error, running op still commits
    run_cyc(0, 1, 1, 0, 0);
    run_cyc(0, 1, 1, 0, 0);
    chk("err_no_start", s_start, 0);
    cpos = -1;
    for (int k = 2; k <= 12; k++) begin
      run_cyc(0, 0, 0, 0, 0);
      if (s_commit) cpos = k;
    end
    chk("err_commit_pos", cpos, 5);
    chk("err_sticky", s_err, 1);
    run_cyc(1, 0, 0, 0, 0);
    run_cyc(0, 0, 0, 0, 0);
    chk("err_cleared", s_err, 0);
    // randomized traffic against the model
    for (int k = 0; k < 2000; k++) begin
      logic [3:0] rop;
      rop = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      run_cyc($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, rop,
              $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
